// File: rtl/cond_exec_stage_pkg.sv
// Shared definitions for the conditional execute stage: word width,
// ALU opcodes, condition codes, flag bit positions and opcode classifiers.
package cond_exec_stage_pkg;

  localparam int WORD_WIDTH = 32;

  // Flag bit positions inside the {C,N,Z,V} nibble.
  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    ALU_AND = 4'h0, ALU_EOR = 4'h1, ALU_SUB = 4'h2, ALU_RSB = 4'h3,
    ALU_ADD = 4'h4, ALU_ADC = 4'h5, ALU_SBC = 4'h6, ALU_RSC = 4'h7,
    ALU_TST = 4'h8, ALU_TEQ = 4'h9, ALU_CMP = 4'hA, ALU_CMN = 4'hB,
    ALU_ORR = 4'hC, ALU_MOV = 4'hD, ALU_BIC = 4'hE, ALU_MVN = 4'hF
  } alu_op_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  // Compare ops update flags but never write a register.
  function automatic logic is_compare(input logic [3:0] op);
    return op inside {ALU_TST, ALU_TEQ, ALU_CMP, ALU_CMN};
  endfunction

  // Arithmetic ops produce a real overflow flag; logical ops keep V.
  function automatic logic is_arith(input logic [3:0] op);
    return op inside {ALU_SUB, ALU_RSB, ALU_ADD, ALU_ADC,
                      ALU_SBC, ALU_RSC, ALU_CMP, ALU_CMN};
  endfunction

  // Ops whose carry-in is the architectural C flag rather than the shifter carry.
  function automatic logic uses_flag_carry(input logic [3:0] op);
    return op inside {ALU_ADC, ALU_SBC, ALU_RSC};
  endfunction

endpackage

// File: rtl/alu.sv
// Data-processing ALU: 16 opcodes, returns result and {C,N,Z,V}.
// For logical ops C is passed through from carry_in and V is reported as 0;
// the caller decides whether to keep the old V.
module alu
  import cond_exec_stage_pkg::*;
(
  input  logic [3:0]            opcode,
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  input  logic                  carry_in,
  output logic [WORD_WIDTH-1:0] y,
  output logic [3:0]            cnzv
);

  logic [WORD_WIDTH-1:0] add_a;
  logic [WORD_WIDTH-1:0] add_b;
  logic                  add_cin;
  logic [WORD_WIDTH:0]   sum;
  logic [WORD_WIDTH-1:0] logic_res;
  logic                  arith;

  // Adder operand selection: subtraction is a + ~b + carry (C = not borrow).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    add_a   = a;
    add_b   = b;
    add_cin = 1'b0;
    case (opcode)
      ALU_SUB, ALU_CMP: begin add_b = ~b; add_cin = 1'b1;     end
      ALU_RSB:          begin add_a = b; add_b = ~a; add_cin = 1'b1; end
      ALU_ADC:          begin add_cin = carry_in;             end
      ALU_SBC:          begin add_b = ~b; add_cin = carry_in; end
      ALU_RSC:          begin add_a = b; add_b = ~a; add_cin = carry_in; end
      default:          ;
    endcase
  end

  assign sum = {1'b0, add_a} + {1'b0, add_b} + (WORD_WIDTH + 1)'(add_cin);

  // Bitwise result for the logical opcodes.
  always_comb begin
    logic_res = b;
    case (opcode)
      ALU_AND, ALU_TST: logic_res = a & b;
      ALU_EOR, ALU_TEQ: logic_res = a ^ b;
      ALU_ORR:          logic_res = a | b;
      ALU_BIC:          logic_res = a & ~b;
      ALU_MVN:          logic_res = ~b;
      default:          logic_res = b;
    endcase
  end

  assign arith = is_arith(opcode);
  assign y     = arith ? sum[WORD_WIDTH-1:0] : logic_res;

  assign cnzv[FLAG_C] = arith ? sum[WORD_WIDTH] : carry_in;
  assign cnzv[FLAG_N] = y[WORD_WIDTH-1];
  assign cnzv[FLAG_Z] = (y == '0);
  assign cnzv[FLAG_V] = arith & (add_a[WORD_WIDTH-1] == add_b[WORD_WIDTH-1])
                              & (y[WORD_WIDTH-1] != add_a[WORD_WIDTH-1]);

endmodule

// File: rtl/cond_check.sv
// Combinational condition evaluator: (cond, {C,N,Z,V}) -> pass.
module cond_check
  import cond_exec_stage_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] cnzv,
  output logic       pass
);

  logic c, n, z, v;

  assign c = cnzv[FLAG_C];
  assign n = cnzv[FLAG_N];
  assign z = cnzv[FLAG_Z];
  assign v = cnzv[FLAG_V];

  // Decode the condition field against the current flags.
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_stage.sv
// Conditional execute stage: evaluates the condition against the NZCV flags,
// drives the ALU, commits flag updates at the accept edge (so the next op sees
// them without a bubble) and holds one result for writeback.
module cond_exec_stage
  import cond_exec_stage_pkg::*;
#(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic                  in_Clk,
  input  logic                  in_Rst_n,
  input  logic                  in_Valid,
  output logic                  out_Ready,
  input  logic [3:0]            in_Cond,
  input  logic [3:0]            in_Opcode,
  input  logic                  in_SetFlags,
  input  logic [3:0]            in_Rd,
  input  logic [WORD_WIDTH-1:0] in_Rn,
  input  logic [WORD_WIDTH-1:0] in_Op2,
  input  logic                  in_ShCarry,
  input  logic                  in_FlagWe,
  input  logic [3:0]            in_FlagData,
  output logic                  out_WbValid,
  input  logic                  in_WbReady,
  output logic [3:0]            out_WbRd,
  output logic [WORD_WIDTH-1:0] out_WbData,
  output logic [3:0]            out_CNZV
);

  logic [3:0]            cnzv_q;
  logic                  wb_valid_q;
  logic [3:0]            wb_rd_q;
  logic [WORD_WIDTH-1:0] wb_data_q;

  logic                  accept;
  logic                  cond_pass;
  logic                  alu_cin;
  logic [WORD_WIDTH-1:0] alu_y;
  logic [3:0]            alu_cnzv;
  logic [3:0]            next_flags;
  logic                  flag_update;
  logic                  writes_back;

  // Single output register without skid: accept only if the slot drains now.
  assign out_Ready = ~wb_valid_q | in_WbReady;
  assign accept    = in_Valid & out_Ready;

  cond_check u_cond_check (
    .cond (in_Cond),
    .cnzv (cnzv_q),
    .pass (cond_pass)
  );

  assign alu_cin = uses_flag_carry(in_Opcode) ? cnzv_q[FLAG_C] : in_ShCarry;

  alu u_alu (
    .opcode   (in_Opcode),
    .a        (in_Rn),
    .b        (in_Op2),
    .carry_in (alu_cin),
    .y        (alu_y),
    .cnzv     (alu_cnzv)
  );

  // Logical ops take C, N, Z from the ALU but leave V untouched.
  always_comb begin
    next_flags = alu_cnzv;
    if (!is_arith(in_Opcode)) next_flags[FLAG_V] = cnzv_q[FLAG_V];
  end

  assign flag_update = accept & cond_pass & (in_SetFlags | is_compare(in_Opcode));
  assign writes_back = cond_pass & ~is_compare(in_Opcode);

  // Flags register: a direct write takes priority over an instruction update.
  always_ff @(posedge in_Clk or negedge in_Rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!in_Rst_n) begin
      cnzv_q <= FLAGS_RESET;
    end else if (in_FlagWe) begin
      cnzv_q <= in_FlagData;
    end else if (flag_update) begin
      cnzv_q <= next_flags;
    end
  end

  // Writeback register: loads on an accepted writing op, otherwise drains when taken.
  always_ff @(posedge in_Clk or negedge in_Rst_n) begin
    if (!in_Rst_n) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else if (accept) begin
      wb_valid_q <= writes_back;
      if (writes_back) begin
        wb_rd_q   <= in_Rd;
        wb_data_q <= alu_y;
      end
    end else if (in_WbReady) begin
      wb_valid_q <= 1'b0;
    end
  end

  assign out_WbValid = wb_valid_q;
  assign out_WbRd    = wb_rd_q;
  assign out_WbData  = wb_data_q;
  assign out_CNZV    = cnzv_q;

endmodule
